dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and the backing data RAM. Consumes the MEM stage's address, write-enable, byte-select, store data and chip-enable. Returns load data with two completion flags, both one level of logic from the MEM stage's stall request:
- hit1_o: read hit.
- hit2_o: memory transaction done.

Parameters:
INDEX_W, 4, index bits; 2^INDEX_W one-word lines
ADDR_W, 32, byte-address width; tag = addr[ADDR_W-1:INDEX_W+2]

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
ce_i  in  1  MEM-stage chip enable (request valid)
we_i  in  1  1 = store, 0 = load
addr_i  in  ADDR_W  byte address; bits [1:0] ignored
sel_i  in  4  byte enables for stores
data_i  in  32  store data
data_o  out  32  load data to MEM stage
hit1_o  out  1  load hit, combinational, same cycle
hit2_o  out  1  one-cycle pulse, memory transaction complete
mem_req_o  out  1  RAM request, held until acknowledged
mem_we_o  out  1  RAM write
mem_addr_o  out  ADDR_W  RAM word address (bits [1:0] = 0)
mem_sel_o  out  4  RAM byte enables
mem_wdata_o  out  32  RAM write data
mem_rdata_i  in  32  RAM read data, valid with ack
mem_ack_i  in  1  RAM acknowledge, sampled on clk

Behaviour:
- Storage per line: valid bit, tag, 32-bit data.
- rst clears all valid bits, FSM goes to IDLE, all outputs 0.
- Latches: lat_addr, lat_we, lat_sel, lat_data; rd_buf (32 bit).
- hit1_o is asserted only in IDLE and only when ce_i && !we_i && valid[idx] && tag match.
- On a hit: data_o = line data; zero-cycle latency; no FSM activity.
- FSM states: IDLE, RD_MISS, WR, DONE.
- IDLE, load miss: latch request, go to RD_MISS.
- IDLE, store (hit or miss): latch request, go to WR.
- IDLE, ce_i = 0: stay.
- RD_MISS:
  - Drives mem_req_o=1, mem_we_o=0, mem_addr_o=lat_addr word-aligned, mem_sel_o=4'b1111.
  - On an edge with mem_ack_i=1: write mem_rdata_i into the line, set valid, write tag, capture rd_buf, go to DONE.
- WR:
  - Drives mem_req_o=1, mem_we_o=1, mem_sel_o=lat_sel, mem_wdata_o=lat_data.
  - On ack: if the line holds the same tag and is valid, merge lat_data into the line bytes enabled by lat_sel; otherwise leave the line untouched (no allocate). Go to DONE.
- DONE: hit2_o=1 for exactly one cycle; data_o=rd_buf (0 after a store); mem_req_o=0; next state IDLE unconditionally.
- Request outputs come only from latched registers and stay stable while mem_req_o=1. They are 0 when mem_req_o=0.
- Minimum miss/store stall is 2 cycles (detect cycle, request cycle with immediate ack, then DONE). Each extra ack-wait cycle adds one cycle.
- ce_i or address change while in RD_MISS/WR is ignored. The latched transaction completes and DONE still pulses.
- After DONE, if the pipeline is held by another stall source, the same store is seen in IDLE again and reissued. This is accepted: stores are idempotent.
- A load reissued after its fill hits via hit1_o.
- Index wrap: addresses differing only in tag map to the same line; a fill replaces the line.
- rst asserted mid-transaction: mem_req_o drops immediately, cache is invalidated, any pending ack is ignored.

Optional Feature:
DCACHE_STATS_EN
- Defined:
  - Adds 32-bit saturating counters hit_cnt_o and miss_cnt_o.
  - hit_cnt_o increments on each clk edge where hit1_o=1.
  - miss_cnt_o increments on each IDLE→RD_MISS transition.
  - Both clear on rst and hold at 32'hFFFFFFFF.
- Not defined: both ports exist and are tied to 0; no counter logic.

Test Plan:
- Reset, load 0x00000040, ack after 3 wait cycles with rdata 0xDEADBEEF:
  - mem_req_o high 4 cycles with mem_addr_o=0x40.
  - hit2_o pulses once with data_o=0xDEADBEEF.
  - Repeated load gives hit1_o=1 in the same cycle, data_o=0xDEADBEEF, no request.
- Store 0x11223344, sel 4'b0011, to cached 0x40:
  - RAM write with sel 0011 and hit2_o pulse.
  - Next load hit returns 0xDEAD3344.
- Store to uncached 0x80:
  - RAM write occurs.
  - Following load 0x80 misses (mem_req_o=1, mem_we_o=0): confirms no allocate.
- Loads 0x40 then 0x440 (same index, INDEX_W=4):
  - Second access misses and replaces the line.
  - Load 0x40 misses again.
- Assert rst during RD_MISS wait:
  - mem_req_o=0 immediately and outputs 0.
  - Late ack ignored.
  - Prior cached address now misses.
- DCACHE_STATS_EN: 2 misses + 5 hits → miss_cnt_o=2, hit_cnt_o=5; without the macro both read 0.

Source files
------------

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
// Optional feature macro: DCACHE_STATS_EN adds saturating hit/miss counters on hit_cnt_o/miss_cnt_o.
module dcache_ctrl #(
   parameter int INDEX_W = 4,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [3:0]        sel_i,
   input  logic [31:0]       data_i,
   output logic [31:0]       data_o,
   output logic              hit1_o,
   output logic              hit2_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_sel_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_ack_i,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
);

   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W - 2;

   typedef enum logic [1:0] {IDLE, RD_MISS, WR, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
   logic              lat_we_q, lat_we_d;
   logic [3:0]        lat_sel_q, lat_sel_d;
   logic [31:0]       lat_data_q, lat_data_d;
   logic [31:0]       rd_buf_q, rd_buf_d;
   logic [LINES-1:0]  valid_q, valid_d;

   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [31:0]       line_q [LINES];

   logic [INDEX_W-1:0] req_idx, lat_idx;
   logic [TAG_W-1:0]   req_tag, lat_tag;
   logic               req_hit, lat_hit;
   logic               line_we;
   logic [31:0]        line_wdata;
   logic [31:0]        merged;
   logic               unused_addr_bits;

   // The byte offset never reaches the RAM; lines are whole words.
   assign unused_addr_bits = ^addr_i[1:0];

   assign req_idx = addr_i[INDEX_W+1:2];
   assign req_tag = addr_i[ADDR_W-1:INDEX_W+2];
   assign lat_idx = lat_addr_q[INDEX_W+1:2];
   assign lat_tag = lat_addr_q[ADDR_W-1:INDEX_W+2];
   assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

   // Load hit is answered in the same cycle, and only while the FSM is idle.
   assign hit1_o = (state_q == IDLE) && ce_i && !we_i && req_hit;
   assign hit2_o = (state_q == DONE);

   // RAM request is decoded from the registered state and latched request only.
   assign mem_req_o   = (state_q == RD_MISS) || (state_q == WR);
   assign mem_we_o    = mem_req_o && lat_we_q;
   assign mem_addr_o  = mem_req_o ? lat_addr_q : '0;
   assign mem_sel_o   = (state_q == RD_MISS) ? 4'b1111 : ((state_q == WR) ? lat_sel_q : 4'b0000);
   assign mem_wdata_o = (state_q == WR) ? lat_data_q : 32'd0;

   // Load data mux: line data on a hit, fill/refill buffer in DONE.
   always_comb begin
      data_o = 32'd0;
      if (hit1_o) begin
         data_o = line_q[req_idx];
      end else if (state_q == DONE) begin
         data_o = rd_buf_q;
      end
   end

   // Byte merge of the latched store into the currently cached word.
   always_comb begin
      merged = line_q[lat_idx];
      for (int b = 0; b < 4; b++) begin
         if (lat_sel_q[b]) begin
            merged[8*b +: 8] = lat_data_q[8*b +: 8];
         end
      end
   end

   // Next-state, request latching and line-update decisions.
   always_comb begin
      state_d    = state_q;
      lat_addr_d = lat_addr_q;
      lat_we_d   = lat_we_q;
      lat_sel_d  = lat_sel_q;
      lat_data_d = lat_data_q;
      rd_buf_d   = rd_buf_q;
      valid_d    = valid_q;
      line_we    = 1'b0;
      line_wdata = merged;
      case (state_q)
         IDLE: begin
            if (ce_i && (we_i || !req_hit)) begin
               lat_addr_d = {addr_i[ADDR_W-1:2], 2'b00};
               lat_we_d   = we_i;
               lat_sel_d  = sel_i;
               lat_data_d = data_i;
               if (we_i) begin
                  rd_buf_d = 32'd0;
                  state_d  = WR;
               end else begin
                  state_d  = RD_MISS;
               end
            end
         end
         RD_MISS: begin
            if (mem_ack_i) begin
               line_we          = 1'b1;
               line_wdata       = mem_rdata_i;
               valid_d[lat_idx] = 1'b1;
               rd_buf_d         = mem_rdata_i;
               state_d          = DONE;
            end
         end
         WR: begin
            if (mem_ack_i) begin
               // Write-through without allocate: only an already-cached word is updated.
               line_we = lat_hit;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state, request latches and valid bits; reset invalidates the cache.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         lat_addr_q <= '0;
         lat_we_q   <= 1'b0;
         lat_sel_q  <= 4'b0000;
         lat_data_q <= 32'd0;
         rd_buf_q   <= 32'd0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         lat_addr_q <= lat_addr_d;
         lat_we_q   <= lat_we_d;
         lat_sel_q  <= lat_sel_d;
         lat_data_q <= lat_data_d;
         rd_buf_q   <= rd_buf_d;
         valid_q    <= valid_d;
      end
   end

   // Tag and data arrays need no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (line_we) begin
         line_q[lat_idx] <= line_wdata;
         tag_q[lat_idx]  <= lat_tag;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   // Saturating event counters: same-cycle hits and load-miss starts.
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (hit1_o && (hit_cnt_q != 32'hFFFF_FFFF)) begin
         hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if ((state_q == IDLE) && (state_d == RD_MISS) && (miss_cnt_q != 32'hFFFF_FFFF)) begin
         miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= 32'd0;
         miss_cnt_q <= 32'd0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`else
   assign hit_cnt_o  = 32'd0;
   assign miss_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - table-driven self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

   logic        clk;
   logic        rst;
   logic        ce_i, we_i;
   logic [31:0] addr_i;
   logic [3:0]  sel_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        hit1_o, hit2_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;
   logic [31:0] hit_cnt_o, miss_cnt_o;

   int checks = 0;
   int failures = 0;

   dcache_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .ce_i       (ce_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .sel_i      (sel_i),
      .data_i     (data_i),
      .data_o     (data_o),
      .hit1_o     (hit1_o),
      .hit2_o     (hit2_o),
      .mem_req_o  (mem_req_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_sel_o  (mem_sel_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i),
      .mem_ack_i  (mem_ack_i),
      .hit_cnt_o  (hit_cnt_o),
      .miss_cnt_o (miss_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ce, we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic        ack;
      logic [31:0] rdata;
      logic        e_req, e_we;
      logic [31:0] e_addr;
      logic [3:0]  e_sel;
      logic [31:0] e_wdata;
      logic        e_hit1, e_hit2;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic ce, input logic we, input logic [31:0] addr, input logic [3:0] sel,
                      input logic [31:0] wdata, input logic ack, input logic [31:0] rdata,
                      input logic e_req, input logic e_we, input logic [31:0] e_addr, input logic [3:0] e_sel,
                      input logic [31:0] e_wdata, input logic e_hit1, input logic e_hit2, input logic [31:0] e_data);
      vec_t v;
      v.ce = ce; v.we = we; v.addr = addr; v.sel = sel; v.wdata = wdata; v.ack = ack; v.rdata = rdata;
      v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_sel = e_sel; v.e_wdata = e_wdata;
      v.e_hit1 = e_hit1; v.e_hit2 = e_hit2; v.e_data = e_data;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_miss(input logic [31:0] a, input logic [31:0] rd);
      ce_i = 1'b1; we_i = 1'b0; addr_i = a; mem_ack_i = 1'b0;
      tick();
      mem_ack_i = 1'b1; mem_rdata_i = rd;
      tick();
      mem_ack_i = 1'b0; ce_i = 1'b0;
      tick();
   endtask

   initial begin
      logic [31:0] exp_hits, exp_misses;

      rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; data_i = '0;
      mem_ack_i = 1'b0; mem_rdata_i = '0;

      //   ce we addr        sel  wdata         ack rdata         req we addr        sel  wdata         h1 h2 data
      add(0, 0, 32'h0,     4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        0, 0, 32'h0);
      // load 0x40 miss with three wait cycles; mid-wait input changes are ignored
      add(1, 0, 32'h40,    4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        0, 0, 32'h0);
      add(1, 0, 32'h40,    4'h0, 32'h0,        0, 32'h0,         1, 0, 32'h40,    4'hF, 32'h0,        0, 0, 32'h0);
      add(0, 0, 32'h100,   4'h0, 32'h0,        0, 32'h0,         1, 0, 32'h40,    4'hF, 32'h0,        0, 0, 32'h0);
      add(1, 1, 32'h200,   4'hF, 32'hFFFFFFFF, 0, 32'h0,         1, 0, 32'h40,    4'hF, 32'h0,        0, 0, 32'h0);
      add(1, 0, 32'h40,    4'h0, 32'h0,        1, 32'hDEADBEEF,  1, 0, 32'h40,    4'hF, 32'h0,        0, 0, 32'h0);
      add(0, 0, 32'h0,     4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        0, 1, 32'hDEADBEEF);
      add(1, 0, 32'h40,    4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        1, 0, 32'hDEADBEEF);
      // store hit with byte merge
      add(1, 1, 32'h40,    4'h3, 32'h11223344, 0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        0, 0, 32'h0);
      add(1, 1, 32'h40,    4'h3, 32'h11223344, 1, 32'h0,         1, 1, 32'h40,    4'h3, 32'h11223344, 0, 0, 32'h0);
      add(0, 0, 32'h0,     4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        0, 1, 32'h0);
      add(1, 0, 32'h43,    4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        1, 0, 32'hDEAD3344);
      // store to uncached 0x80 (same index, other tag): no allocate, line untouched
      add(1, 1, 32'h80,    4'hF, 32'hAABBCCDD, 0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        0, 0, 32'h0);
      add(0, 0, 32'h0,     4'h0, 32'h0,        1, 32'h0,         1, 1, 32'h80,    4'hF, 32'hAABBCCDD, 0, 0, 32'h0);
      add(0, 0, 32'h0,     4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        0, 1, 32'h0);
      add(1, 0, 32'h40,    4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        1, 0, 32'hDEAD3344);
      add(1, 0, 32'h80,    4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        0, 0, 32'h0);
      add(1, 0, 32'h80,    4'h0, 32'h0,        1, 32'h55667788,  1, 0, 32'h80,    4'hF, 32'h0,        0, 0, 32'h0);
      add(0, 0, 32'h0,     4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        0, 1, 32'h55667788);
      // index aliasing: 0x40 then 0x440 replace line 0 in turn
      add(1, 0, 32'h40,    4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        0, 0, 32'h0);
      add(1, 0, 32'h40,    4'h0, 32'h0,        1, 32'h40404040,  1, 0, 32'h40,    4'hF, 32'h0,        0, 0, 32'h0);
      add(0, 0, 32'h0,     4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        0, 1, 32'h40404040);
      add(1, 0, 32'h40,    4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        1, 0, 32'h40404040);
      add(1, 0, 32'h440,   4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        0, 0, 32'h0);
      add(1, 0, 32'h440,   4'h0, 32'h0,        1, 32'h44044004,  1, 0, 32'h440,   4'hF, 32'h0,        0, 0, 32'h0);
      add(0, 0, 32'h0,     4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        0, 1, 32'h44044004);
      add(1, 0, 32'h440,   4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        1, 0, 32'h44044004);
      add(1, 0, 32'h40,    4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        0, 0, 32'h0);
      add(1, 0, 32'h40,    4'h0, 32'h0,        1, 32'hDEADBEEF,  1, 0, 32'h40,    4'hF, 32'h0,        0, 0, 32'h0);
      add(0, 0, 32'h0,     4'h0, 32'h0,        0, 32'h0,         0, 0, 32'h0,     4'h0, 32'h0,        0, 1, 32'hDEADBEEF);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 0, {31'd0, mem_req_o}, 32'd0);
      chk("rst_hit2", 0, {31'd0, hit2_o}, 32'd0);
      chk("rst_data", 0, data_o, 32'd0);
      chk("rst_hitcnt", 0, hit_cnt_o, 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < vecs.size(); i++) begin
         ce_i = vecs[i].ce; we_i = vecs[i].we; addr_i = vecs[i].addr; sel_i = vecs[i].sel;
         data_i = vecs[i].wdata; mem_ack_i = vecs[i].ack; mem_rdata_i = vecs[i].rdata;
         @(negedge clk);
         chk("mem_req", i, {31'd0, mem_req_o}, {31'd0, vecs[i].e_req});
         chk("mem_we", i, {31'd0, mem_we_o}, {31'd0, vecs[i].e_we});
         chk("mem_addr", i, mem_addr_o, vecs[i].e_addr);
         chk("mem_sel", i, {28'd0, mem_sel_o}, {28'd0, vecs[i].e_sel});
         chk("mem_wdata", i, mem_wdata_o, vecs[i].e_wdata);
         chk("hit1", i, {31'd0, hit1_o}, {31'd0, vecs[i].e_hit1});
         chk("hit2", i, {31'd0, hit2_o}, {31'd0, vecs[i].e_hit2});
         chk("data", i, data_o, vecs[i].e_data);
         tick();
      end

      // reset in the middle of a load-miss wait
      ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h44; mem_ack_i = 1'b0;
      tick();
      ce_i = 1'b0;
      chk("midrst_req_before", 0, {31'd0, mem_req_o}, 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_req", 0, {31'd0, mem_req_o}, 32'd0);
      chk("midrst_addr", 0, mem_addr_o, 32'd0);
      chk("midrst_sel", 0, {28'd0, mem_sel_o}, 32'd0);
      chk("midrst_data", 0, data_o, 32'd0);
      mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
      tick();
      rst = 1'b0;
      tick();
      mem_ack_i = 1'b0;
      chk("lateack_req", 0, {31'd0, mem_req_o}, 32'd0);
      chk("lateack_hit2", 0, {31'd0, hit2_o}, 32'd0);
      ce_i = 1'b1; addr_i = 32'h44;
      #1;
      chk("lateack_hit1", 0, {31'd0, hit1_o}, 32'd0);
      addr_i = 32'h40;
      #1;
      chk("inval_hit1", 0, {31'd0, hit1_o}, 32'd0);
      chk("inval_data", 0, data_o, 32'd0);
      ce_i = 1'b0;
      chk("cnt_clr_hit", 0, hit_cnt_o, 32'd0);
      chk("cnt_clr_miss", 0, miss_cnt_o, 32'd0);
      tick();

      // two misses followed by five hits
      load_miss(32'h40, 32'hA0A0A0A0);
      load_miss(32'h44, 32'hB1B1B1B1);
      ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h40;
      #1;
      chk("stats_hit_data40", 0, data_o, 32'hA0A0A0A0);
      repeat (3) tick();
      addr_i = 32'h44;
      #1;
      chk("stats_hit_data44", 0, data_o, 32'hB1B1B1B1);
      chk("stats_req_on_hit", 0, {31'd0, mem_req_o}, 32'd0);
      repeat (2) tick();
      ce_i = 1'b0;
      tick();
`ifdef DCACHE_STATS_EN
      exp_hits = 32'd5; exp_misses = 32'd2;
`else
      exp_hits = 32'd0; exp_misses = 32'd0;
`endif
      chk("hit_cnt", 0, hit_cnt_o, exp_hits);
      chk("miss_cnt", 0, miss_cnt_o, exp_misses);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
